jt900h_dmpseq: RTL and testbench
================================

Name: jt900h_dmpseq

Overview:
- Debug snapshot sequencer for the JT900H register file dump port.
- On a trigger it requests a CPU hold and waits for acknowledge. It then walks the dump address space (accumulators, pointers, status register) and captures the bytes into a local buffer.
- It releases the hold and streams a framed packet over a valid/ready byte interface for the debug UART/OSD.
- It sits beside the register file in the CPU top level and is the only driver of the register file dump address.

Parameters:
- NBYTES, 82, number of dump bytes captured (addresses 0..NBYTES-1; 0-63 accumulators, 64-79 pointers, 80-81 SR).
- HEADER, 8'hA5, first byte of every packet.
- PERIOD, 0, auto-trigger interval in cen ticks; 0 disables auto-trigger.

Ports:
- rst  in  1  asynchronous reset, active-high
- clk  in  1  clock
- cen  in  1  CPU clock enable; used only by the PERIOD counter
- start  in  1  single-cycle manual trigger
- hold_req  out  1  request to freeze the CPU (cen gating done outside)
- hold_ack  in  1  CPU frozen; register file contents stable
- dmp_addr  out  8  dump address to the register file
- dmp_din  in  8  dump data from the register file (combinational from dmp_addr)
- tdata  out  8  stream byte
- tvalid  out  1  stream byte valid
- tready  in  1  sink accepts byte
- tlast  out  1  marks the checksum byte
- busy  out  1  high in any state other than IDLE
- overrun  out  1  one-cycle pulse when a trigger is dropped

Behaviour:
- Reset values: hold_req=0, dmp_addr=0, tdata=0, tvalid=0, tlast=0, busy=0, overrun=0. Reset also clears the state to IDLE, the address counter, the checksum and the PERIOD counter. Reset mid-operation aborts the packet silently with no partial tlast.
- Trigger: start, or (PERIOD!=0 and the PERIOD counter wraps).
- PERIOD counter: increments on cen, wraps from PERIOD-1 to 0. The wrap produces a one-cycle internal trigger.
- Trigger in IDLE: go to HOLD.
- Trigger in any other state: ignored, and overrun=1 for that cycle. A simultaneous start and periodic wrap counts as one trigger.
- States and transitions:
  - IDLE: hold_req=0, tvalid=0.
  - HOLD: hold_req=1. Stay until hold_ack=1, with no timeout. Then go to CAPTURE with addr=0 and checksum=HEADER.
  - CAPTURE: hold_req=1, dmp_addr=addr. Each clk: buf[addr]<=dmp_din, checksum<=checksum+dmp_din, addr<=addr+1. When addr==NBYTES-1 the byte is written and the state moves to SEND_HDR. Duration is exactly NBYTES cycles. hold_ack deasserting during CAPTURE is not checked; the CPU top level keeps hold_ack high while hold_req=1.
  - SEND_HDR: hold_req=0 and dmp_addr=0 from the first cycle of this state. tvalid=1, tdata=HEADER. On tready go to SEND_DATA with idx=0.
  - SEND_DATA: tvalid=1, tdata=buf[idx]. On tready: idx++. After idx==NBYTES-1 is accepted, go to SEND_SUM.
  - SEND_SUM: tvalid=1, tdata=-checksum (two's complement), tlast=1. On tready go to IDLE.
- Stream rules:
  - tdata, tvalid and tlast are registered and stay stable while tvalid=1 and tready=0.
  - tvalid never drops before acceptance.
  - Back-to-back bytes are allowed: at most one byte per clk when tready stays high.
  - A packet is NBYTES+2 bytes. The 8-bit sum of all its bytes is 0.
- Latency:
  - start to hold_req: 1 clk.
  - hold_ack to first dmp_addr=0 capture cycle: 1 clk.
  - Header tvalid appears the clk after the last capture.
  - With tready tied high, the packet finishes NBYTES+2 clks after the header is first presented.
- Buffer is an NBYTES x 8 register array. Addr and idx are 7-bit; behaviour for NBYTES>128 is not supported.
- dmp_addr stays 0 outside CAPTURE.

Test Plan:
- Reset with tready=1 and PERIOD=0 -> all outputs 0. Pulse start -> hold_req=1 next clk. Hold hold_ack low 10 clks -> state stays HOLD, dmp_addr=0, no tvalid.
- Preload XWA0=0x11223344 and SR=0xF8C5 in the register model. Trigger, ack, tready=1 -> stream A5, 44,33,22,11, ... byte 81 = F8, byte 82 = C5, then checksum with tlast=1. 84 bytes total, 8-bit sum = 0.
- tready toggling pseudo-randomly (50%) -> tdata/tvalid stable while stalled, and the byte sequence is identical to the previous case.
- start pulsed during CAPTURE and during SEND_DATA -> overrun pulses 1 clk each time, the packet is unaffected, and no second packet follows.
- PERIOD=200 with cen at 1/2 clk -> trigger every 400 clk. Hold tready=0 across a wrap -> overrun pulse; after release the next wrap starts a new packet.
- Assert rst in the middle of SEND_DATA -> all outputs 0 immediately, no tlast. The next start produces a complete, correct packet.

Source files
------------

// File: rtl/jt900h_dmpseq.sv
// jt900h_dmpseq: debug snapshot sequencer for the JT900H register file dump port.
// On a trigger it holds the CPU, copies NBYTES dump bytes into a local buffer,
// releases the CPU, then streams HEADER, the bytes and a zero-sum checksum
// over a valid/ready byte interface.
module jt900h_dmpseq #(
  parameter int         NBYTES = 82,
  parameter logic [7:0] HEADER = 8'hA5,
  parameter int         PERIOD = 0
)(
  input  logic       rst,
  input  logic       clk,
  input  logic       cen,
  input  logic       start,
  output logic       hold_req,
  input  logic       hold_ack,
  output logic [7:0] dmp_addr,
  input  logic [7:0] dmp_din,
  output logic [7:0] tdata,
  output logic       tvalid,
  input  logic       tready,
  output logic       tlast,
  output logic       busy,
  output logic       overrun
);

  // Index of the final dump byte; address and stream index are 7 bits wide.
  localparam logic [6:0] LAST = 7'(NBYTES - 1);

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    CAPTURE,
    SEND_HDR,
    SEND_DATA,
    SEND_SUM
  } state_t;

  state_t     state;
  logic [6:0] idx;
  logic [7:0] checksum;
  logic [7:0] cap_mem [0:NBYTES-1];
  logic       period_trig;
  logic       trig;

  generate
    if (PERIOD != 0) begin : g_period
      localparam int            PW   = (PERIOD > 1) ? $clog2(PERIOD) : 1;
      localparam logic [PW-1:0] PMAX = PW'(PERIOD - 1);
      logic [PW-1:0] pcnt;

      // Counts cen ticks and wraps from PERIOD-1 back to 0.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          pcnt <= '0;
        else if (cen)
          pcnt <= (pcnt == PMAX) ? '0 : pcnt + PW'(1);
      end

      // The wrapping tick itself is the one-cycle periodic trigger.
      assign period_trig = cen && (pcnt == PMAX);
    end else begin : g_noperiod
      logic unused_cen;
      assign unused_cen  = cen;
      assign period_trig = 1'b0;
    end
  endgenerate

  // A simultaneous manual and periodic trigger merges into one.
  assign trig = start | period_trig;

  // Sequencer: hold handshake, capture walk, and the registered stream outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_req <= 1'b0;
      dmp_addr <= 8'd0;
      idx      <= 7'd0;
      checksum <= 8'd0;
      tdata    <= 8'd0;
      tvalid   <= 1'b0;
      tlast    <= 1'b0;
      busy     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      // Any trigger outside IDLE is dropped and flagged for one cycle.
      overrun <= trig && (state != IDLE);
      case (state)
        IDLE: begin
          if (trig) begin
            state    <= HOLD;
            hold_req <= 1'b1;
            busy     <= 1'b1;
          end
        end
        HOLD: begin
          if (hold_ack) begin
            state    <= CAPTURE;
            dmp_addr <= 8'd0;
            checksum <= HEADER;
          end
        end
        CAPTURE: begin
          checksum <= checksum + dmp_din;
          if (dmp_addr[6:0] == LAST) begin
            // Last byte is being stored now; the CPU is released and the
            // header is presented on the very next cycle.
            state    <= SEND_HDR;
            hold_req <= 1'b0;
            dmp_addr <= 8'd0;
            tvalid   <= 1'b1;
            tdata    <= HEADER;
          end else begin
            dmp_addr <= dmp_addr + 8'd1;
          end
        end
        SEND_HDR: begin
          if (tready) begin
            state <= SEND_DATA;
            idx   <= 7'd0;
            tdata <= cap_mem[0];
          end
        end
        SEND_DATA: begin
          if (tready) begin
            if (idx == LAST) begin
              state <= SEND_SUM;
              tdata <= 8'd0 - checksum;
              tlast <= 1'b1;
            end else begin
              idx   <= idx + 7'd1;
              tdata <= cap_mem[idx + 7'd1];
            end
          end
        end
        SEND_SUM: begin
          if (tready) begin
            state  <= IDLE;
            tvalid <= 1'b0;
            tlast  <= 1'b0;
            tdata  <= 8'd0;
            busy   <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          hold_req <= 1'b0;
          dmp_addr <= 8'd0;
          tvalid   <= 1'b0;
          tlast    <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

  // Snapshot storage, written once per capture cycle; contents need no reset.
  always_ff @(posedge clk) begin
    if (state == CAPTURE)
      cap_mem[dmp_addr[6:0]] <= dmp_din;
  end

endmodule

// File: tb/tb_jt900h_dmpseq.sv
`timescale 1ns/1ps
module tb_jt900h_dmpseq;
  localparam int NB = 82;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main instance (PERIOD=0)
  logic       rst, cen, start, hold_ack, tready;
  logic       ack_auto, ack_manual;
  logic       hold_req, tvalid, tlast, busy, overrun;
  logic [7:0] dmp_addr, dmp_din, tdata;

  // Periodic instance (PERIOD=200)
  logic       rst_p, cen_p, start_p, hold_ack_p, tready_p;
  logic       hold_req_p, tvalid_p, tlast_p, busy_p, overrun_p;
  logic [7:0] dmp_addr_p, dmp_din_p, tdata_p;

  logic [7:0] regs [0:255];
  assign dmp_din    = regs[dmp_addr];
  assign dmp_din_p  = regs[dmp_addr_p];
  assign hold_ack   = ack_auto ? hold_req : ack_manual;
  assign hold_ack_p = hold_req_p;

  jt900h_dmpseq #(.NBYTES(NB), .HEADER(8'hA5), .PERIOD(0)) dut (
    .rst(rst), .clk(clk), .cen(cen), .start(start),
    .hold_req(hold_req), .hold_ack(hold_ack),
    .dmp_addr(dmp_addr), .dmp_din(dmp_din),
    .tdata(tdata), .tvalid(tvalid), .tready(tready), .tlast(tlast),
    .busy(busy), .overrun(overrun)
  );

  jt900h_dmpseq #(.NBYTES(NB), .HEADER(8'hA5), .PERIOD(200)) dut_p (
    .rst(rst_p), .clk(clk), .cen(cen_p), .start(start_p),
    .hold_req(hold_req_p), .hold_ack(hold_ack_p),
    .dmp_addr(dmp_addr_p), .dmp_din(dmp_din_p),
    .tdata(tdata_p), .tvalid(tvalid_p), .tready(tready_p), .tlast(tlast_p),
    .busy(busy_p), .overrun(overrun_p)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_tlast  = 0;
  int stall_viol = 0;
  int n, tl0;
  logic [8:0] pkt [$];
  logic [7:0] exp_pkt [0:NB+1];

  // Periodic-instance observations
  int   rise_cyc [$];
  int   ovr_p_cnt = 0;
  int   ovr_p_cyc = 0;
  logic prev_hr_p = 1'b0;

  // Stream monitor state
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'd0;
  logic       prev_last  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // cen at half the clock rate for the periodic instance
  initial begin
    cen_p = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cen_p = ~cen_p;
    end
  end

  // Main stream monitor: records accepted bytes and checks stall stability
  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(tvalid && tdata == prev_data && tlast == prev_last))
        stall_viol++;
      if (tvalid && tready) begin
        pkt.push_back({tlast, tdata});
        if (tlast) n_tlast++;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
    end
  end

  // Periodic monitor: hold_req rising cycles and overrun pulses
  always @(negedge clk) begin
    if (hold_req_p && !prev_hr_p) rise_cyc.push_back(cyc);
    prev_hr_p = hold_req_p;
    if (overrun_p) begin
      ovr_p_cnt++;
      ovr_p_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic build_expected();
    logic [7:0] s;
    exp_pkt[0] = 8'hA5;
    s = 8'hA5;
    for (int i = 0; i < NB; i++) begin
      exp_pkt[i+1] = regs[i];
      s = s + regs[i];
    end
    exp_pkt[NB+1] = 8'd0 - s;
  endtask

  task automatic check_packet(input string tag);
    logic [8:0] got;
    logic [7:0] sum;
    sum = 8'd0;
    check($sformatf("%s len", tag), 32'(pkt.size()), 32'(NB + 2));
    for (int i = 0; i < NB + 2; i++) begin
      if (i < pkt.size()) got = pkt[i];
      else got = 9'h1FF;
      sum = sum + got[7:0];
      check($sformatf("%s byte%0d", tag, i), 32'(got), 32'({(i == NB + 1), exp_pkt[i]}));
    end
    check($sformatf("%s sum", tag), 32'(sum), 32'(0));
  endtask

  task automatic run_packet(input string tag);
    pkt.delete();
    tl0 = n_tlast;
    pulse_start();
    n = 0;
    while (n_tlast == tl0 && n < 400) begin
      tick();
      n++;
    end
    check($sformatf("%s done in bound", tag), 32'(n_tlast), 32'(tl0 + 1));
    tick();
    check_packet(tag);
  endtask

  initial begin
    rst = 1'b1; rst_p = 1'b1; cen = 1'b0; start = 1'b0; start_p = 1'b0;
    tready = 1'b1; tready_p = 1'b1; ack_auto = 1'b0; ack_manual = 1'b0;
    for (int i = 0; i < 256; i++) regs[i] = 8'(i * 37 + 5);
    regs[0] = 8'h44; regs[1] = 8'h33; regs[2] = 8'h22; regs[3] = 8'h11;
    regs[80] = 8'hF8; regs[81] = 8'hC5;
    build_expected();

    // Reset state
    repeat (3) tick();
    check("reset outputs", 32'({hold_req, dmp_addr, tdata, tvalid, tlast, busy, overrun}), 32'(0));
    rst = 1'b0;
    tick();
    check("idle after reset", 32'({hold_req, dmp_addr, tdata, tvalid, tlast, busy, overrun}), 32'(0));

    // start -> hold_req next clk, then wait in HOLD without ack
    pulse_start();
    check("hold_req latency", 32'(hold_req), 32'(1));
    check("busy in HOLD", 32'(busy), 32'(1));
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("HOLD wait %0d", i), 32'({hold_req, dmp_addr, tvalid}), 32'({1'b1, 8'd0, 1'b0}));
    end

    // Ack: capture starts at address 0 one clk later
    pkt.delete();
    tl0 = n_tlast;
    ack_manual = 1'b1;
    tick();
    check("capture addr0", 32'({hold_req, dmp_addr}), 32'({1'b1, 8'd0}));
    tick();
    check("capture addr1", 32'(dmp_addr), 32'(1));
    ack_auto = 1'b1;
    n = 1;
    while (!tvalid && n < 300) begin
      tick();
      n++;
    end
    check("capture length", 32'(n), 32'(NB));
    check("header present", 32'({hold_req, dmp_addr, tdata, tlast}), 32'({1'b0, 8'd0, 8'hA5, 1'b0}));
    n = 0;
    while (tvalid && n < 300) begin
      tick();
      n++;
    end
    check("stream length", 32'(n), 32'(NB + 2));
    check_packet("direct");
    check("XWA0 low byte", 32'(pkt[1]), 32'(9'h044));
    check("XWA0 high byte", 32'(pkt[4]), 32'(9'h011));
    check("SR high byte", 32'(pkt[81]), 32'(9'h0F8));
    check("SR low byte", 32'(pkt[82]), 32'(9'h0C5));
    check("one tlast", 32'(n_tlast), 32'(tl0 + 1));
    check("idle after packet", 32'({busy, tvalid, tlast, hold_req}), 32'(0));

    // Random back-pressure
    pkt.delete();
    tl0 = n_tlast;
    pulse_start();
    n = 0;
    while (n_tlast == tl0 && n < 2000) begin
      tready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    tready = 1'b1;
    check("stall packet done", 32'(n_tlast), 32'(tl0 + 1));
    tick();
    check_packet("stalled");
    check("stall stability", 32'(stall_viol), 32'(0));

    // Triggers during CAPTURE and SEND_DATA are dropped with overrun
    pkt.delete();
    tl0 = n_tlast;
    pulse_start();
    n = 0;
    while (dmp_addr != 8'd10 && n < 100) begin
      tick();
      n++;
    end
    check("reached capture", 32'(dmp_addr), 32'(10));
    pulse_start();
    check("overrun capture", 32'(overrun), 32'(1));
    tick();
    check("overrun capture 1clk", 32'(overrun), 32'(0));
    n = 0;
    while (pkt.size() < 5 && n < 200) begin
      tick();
      n++;
    end
    check("reached send_data", 32'(pkt.size() >= 5), 32'(1));
    pulse_start();
    check("overrun send", 32'(overrun), 32'(1));
    tick();
    check("overrun send 1clk", 32'(overrun), 32'(0));
    n = 0;
    while (n_tlast == tl0 && n < 300) begin
      tick();
      n++;
    end
    repeat (20) tick();
    check("no second packet", 32'({n_tlast[7:0], busy, hold_req}), 32'({8'(tl0 + 1), 1'b0, 1'b0}));
    check_packet("overrun");

    // Reset in the middle of SEND_DATA
    pkt.delete();
    tl0 = n_tlast;
    pulse_start();
    n = 0;
    while (pkt.size() < 10 && n < 300) begin
      tick();
      n++;
    end
    check("reached send_data rst", 32'(busy && tvalid && !tlast), 32'(1));
    rst = 1'b1;
    #1;
    check("rst mid outputs", 32'({hold_req, dmp_addr, tdata, tvalid, tlast, busy, overrun}), 32'(0));
    repeat (2) tick();
    rst = 1'b0;
    repeat (5) tick();
    check("no tlast after abort", 32'(n_tlast), 32'(tl0));
    check("idle after abort", 32'({busy, tvalid, hold_req}), 32'(0));
    run_packet("after reset");

    // Periodic trigger every 400 clk
    rst_p = 1'b0;
    n = 0;
    while (rise_cyc.size() < 2 && n < 1200) begin
      tick();
      n++;
    end
    check("period two triggers", 32'(rise_cyc.size() >= 2), 32'(1));
    check("period interval", 32'(rise_cyc[1] - rise_cyc[0]), 32'(400));
    n = 0;
    while (!tvalid_p && n < 200) begin
      tick();
      n++;
    end
    check("period packet streaming", 32'(tvalid_p), 32'(1));
    tready_p = 1'b0;
    n = 0;
    while (ovr_p_cnt == 0 && n < 600) begin
      tick();
      n++;
    end
    check("period overrun seen", 32'(ovr_p_cnt), 32'(1));
    check("period overrun at wrap", 32'(ovr_p_cyc - rise_cyc[1]), 32'(400));
    check("period stalled busy", 32'({busy_p, tvalid_p}), 32'({1'b1, 1'b1}));
    tready_p = 1'b1;
    n = 0;
    while (busy_p && n < 300) begin
      tick();
      n++;
    end
    check("period packet released", 32'(busy_p), 32'(0));
    n = 0;
    while (rise_cyc.size() < 3 && n < 800) begin
      tick();
      n++;
    end
    check("period next trigger", 32'(rise_cyc.size() >= 3), 32'(1));
    check("period next interval", 32'(rise_cyc[2] - rise_cyc[1]), 32'(800));
    check("period single overrun", 32'(ovr_p_cnt), 32'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
